// File: rtl/parking_gate_arbiter_if.sv
// Lane-request / barrier bundle between the four lane requesters (plus the occupancy counter
// flags and the loop sensor) and parking_gate_arbiter.
//   req[3:0]            level requests: [0] uni entry, [1] guest entry, [2] uni exit, [3] guest exit
//   *_space_ok          counter flags, vacancy > 0 per class
//   *_occupied          counter flags, parked > 0 per class
//   car_passed          loop sensor, high while a car is under the barrier
//   gnt / deny          one-hot single-cycle acknowledge per lane
//   gate_open           barrier up
//   car_entered/exited  single-cycle commit pulses to the counter, is_uni_* qualify them
//   timeout             single-cycle pulse, granted car never arrived
//   busy / state        FSM status for debug
interface parking_gate_arbiter_if;
  logic [3:0] req;
  logic       uni_space_ok;
  logic       guest_space_ok;
  logic       uni_occupied;
  logic       guest_occupied;
  logic       car_passed;
  logic [3:0] gnt;
  logic [3:0] deny;
  logic       gate_open;
  logic       car_entered;
  logic       car_exited;
  logic       is_uni_car_entered;
  logic       is_uni_car_exited;
  logic       timeout;
  logic       busy;
  logic [2:0] state;

  modport master (
    output req, uni_space_ok, guest_space_ok, uni_occupied, guest_occupied, car_passed,
    input  gnt, deny, gate_open, car_entered, car_exited, is_uni_car_entered,
           is_uni_car_exited, timeout, busy, state
  );

  modport slave (
    input  req, uni_space_ok, guest_space_ok, uni_occupied, guest_occupied, car_passed,
    output gnt, deny, gate_open, car_entered, car_exited, is_uni_car_entered,
           is_uni_car_exited, timeout, busy, state
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Shares one parking barrier among four lane requesters (uni/guest entry, uni/guest exit).
// Requests are served round-robin; entries are checked against the counter's space flags and
// exits against its occupancy flags. Runs the barrier FSM and emits exactly one commit pulse
// per physical pass.
// Ports:
//   clk    system clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    parking_gate_arbiter_if.slave, see the interface for the signal list
// Parameters:
//   OPEN_TIMEOUT  cycles the gate stays open waiting for a car before aborting (>= 1)
//   COOLDOWN      cycles the gate stays closed between transactions (>= 1)
module parking_gate_arbiter #(
  parameter int unsigned OPEN_TIMEOUT = 30,
  parameter int unsigned COOLDOWN     = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  parking_gate_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StGrant    = 3'd1,
    StOpenWait = 3'd2,
    StOpenPass = 3'd3,
    StCooldown = 3'd4
  } state_e;

  localparam int unsigned TimerW = (OPEN_TIMEOUT > 1) ? $clog2(OPEN_TIMEOUT) : 1;
  localparam int unsigned CoolW  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(OPEN_TIMEOUT - 1);
  localparam logic [CoolW-1:0]  CoolLast  = CoolW'(COOLDOWN - 1);

  state_e            state_q;
  logic [1:0]        ptr_q;
  logic              lane_exit_q;
  logic [TimerW-1:0] timer_q;
  logic [CoolW-1:0]  cool_q;
  logic [3:0]        gnt_q;
  logic [3:0]        deny_q;
  logic              gate_q;
  logic              entered_q;
  logic              exited_q;
  logic              uni_in_q;
  logic              uni_out_q;
  logic              timeout_q;

  // Lane k is serviceable when its counter flag allows the move.
  logic [3:0] eligible;
  assign eligible = {bus.guest_occupied, bus.uni_occupied, bus.guest_space_ok, bus.uni_space_ok};

  // First set request at or after ptr_q, wrapping mod 4.
  logic       pick_valid;
  logic [1:0] pick_idx;
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      if (!pick_valid && bus.req[ptr_q + 2'(i)]) begin
        pick_valid = 1'b1;
        pick_idx   = ptr_q + 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd0;
      lane_exit_q <= 1'b0;
      timer_q     <= '0;
      cool_q      <= '0;
      gnt_q       <= 4'd0;
      deny_q      <= 4'd0;
      gate_q      <= 1'b0;
      entered_q   <= 1'b0;
      exited_q    <= 1'b0;
      uni_in_q    <= 1'b0;
      uni_out_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      gnt_q     <= 4'd0;
      deny_q    <= 4'd0;
      entered_q <= 1'b0;
      exited_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            ptr_q <= pick_idx + 2'd1;
            if (eligible[pick_idx]) begin
              state_q     <= StGrant;
              lane_exit_q <= pick_idx[1];
              gnt_q       <= 4'd1 << pick_idx;
              // Qualifiers settle with the grant so they lead any commit by several cycles.
              uni_in_q    <= (pick_idx == 2'd0);
              uni_out_q   <= (pick_idx == 2'd2);
            end else begin
              deny_q <= 4'd1 << pick_idx;
            end
          end
        end
        StGrant: begin
          state_q <= StOpenWait;
          gate_q  <= 1'b1;
          timer_q <= '0;
        end
        StOpenWait: begin
          // An arriving car wins over an expiring timer.
          if (bus.car_passed) begin
            state_q <= StOpenPass;
          end else if (timer_q == TimerLast) begin
            state_q   <= StCooldown;
            gate_q    <= 1'b0;
            timeout_q <= 1'b1;
            cool_q    <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StOpenPass: begin
          if (!bus.car_passed) begin
            state_q   <= StCooldown;
            gate_q    <= 1'b0;
            cool_q    <= '0;
            entered_q <= ~lane_exit_q;
            exited_q  <= lane_exit_q;
          end
        end
        StCooldown: begin
          if (cool_q == CoolLast) begin
            state_q <= StIdle;
          end else begin
            cool_q <= cool_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          gate_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt                = gnt_q;
  assign bus.deny               = deny_q;
  assign bus.gate_open          = gate_q;
  assign bus.car_entered        = entered_q;
  assign bus.car_exited         = exited_q;
  assign bus.is_uni_car_entered = uni_in_q;
  assign bus.is_uni_car_exited  = uni_out_q;
  assign bus.timeout            = timeout_q;
  assign bus.busy               = (state_q != StIdle);
  assign bus.state              = state_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_parking_gate_arbiter;

  localparam int To = 30;
  localparam int Cd = 2;

  logic clk;
  logic rst_n;
  bit   started;
  int   vectors;
  int   miscompares;

  parking_gate_arbiter_if bus ();

  parking_gate_arbiter #(
    .OPEN_TIMEOUT(To),
    .COOLDOWN    (Cd)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: phase numbers are the documented debug encoding; waits are countdowns.
  typedef struct {
    int         phase;
    int         lane;
    int         ptr;
    int         wait_left;
    int         cool_left;
    logic [3:0] gnt;
    logic [3:0] deny;
    logic       gate;
    logic       entered;
    logic       exited;
    logic       uni_in;
    logic       uni_out;
    logic       tmo;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.phase = 0; r.lane = 0; r.ptr = 0; r.wait_left = 0; r.cool_left = 0;
    r.gnt = 4'd0; r.deny = 4'd0; r.gate = 1'b0; r.entered = 1'b0; r.exited = 1'b0;
    r.uni_in = 1'b0; r.uni_out = 1'b0; r.tmo = 1'b0;
    return r;
  endfunction

  function automatic model_t model_next(model_t c, logic [3:0] req, logic [3:0] ok, logic car);
    model_t n = c;
    int     k;
    n.gnt = 4'd0; n.deny = 4'd0; n.entered = 1'b0; n.exited = 1'b0; n.tmo = 1'b0;
    case (c.phase)
      0: begin
        k = -1;
        for (int i = 0; i < 4; i++) if (k < 0 && req[(c.ptr + i) % 4]) k = (c.ptr + i) % 4;
        if (k >= 0) begin
          n.ptr = (k + 1) % 4;
          if (ok[k]) begin
            n.phase = 1; n.lane = k; n.gnt[k] = 1'b1;
            n.uni_in = (k == 0); n.uni_out = (k == 2);
          end else begin
            n.deny[k] = 1'b1;
          end
        end
      end
      1: begin n.phase = 2; n.gate = 1'b1; n.wait_left = To; end
      2: begin
        if (car) n.phase = 3;
        else if (c.wait_left == 1) begin
          n.phase = 4; n.gate = 1'b0; n.tmo = 1'b1; n.cool_left = Cd;
        end else n.wait_left = c.wait_left - 1;
      end
      3: begin
        if (!car) begin
          n.phase = 4; n.gate = 1'b0; n.cool_left = Cd;
          if (c.lane < 2) n.entered = 1'b1; else n.exited = 1'b1;
        end
      end
      default: begin
        if (c.cool_left == 1) n.phase = 0; else n.cool_left = c.cool_left - 1;
      end
    endcase
    return n;
  endfunction

  function automatic logic [17:0] model_vec(model_t c);
    return {c.gnt, c.deny, c.gate, c.entered, c.exited, c.uni_in, c.uni_out, c.tmo,
            (c.phase != 0), 3'(c.phase)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else m <= model_next(m, bus.req,
                         {bus.guest_occupied, bus.uni_occupied, bus.guest_space_ok,
                          bus.uni_space_ok}, bus.car_passed);
  end

  // Per-cycle compare on the inactive edge.
  initial begin
    logic [17:0] got;
    logic [17:0] exp;
    forever begin
      @(negedge clk);
      if (started) begin
        got = {bus.gnt, bus.deny, bus.gate_open, bus.car_entered, bus.car_exited,
               bus.is_uni_car_entered, bus.is_uni_car_exited, bus.timeout, bus.busy, bus.state};
        exp = model_vec(m);
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, got, exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    {bus.guest_occupied, bus.uni_occupied, bus.guest_space_ok, bus.uni_space_ok} = f;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input string name, input logic [3:0] exp);
    int n = 0;
    while (bus.gnt == 4'd0 && n < 20) begin tick(); n++; end
    check(name, bus.gnt, exp);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.state != 3'd0 && n < 60) begin tick(); n++; end
    check(name, bus.state, 0);
  endtask

  // Called while the grant is visible: opens, passes a car for one cycle, checks the commit.
  task automatic pass_car(input string name, input int lane);
    tick();
    check({name, "_gate"}, bus.gate_open, 1);
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    tick();
    check({name, "_commit"}, {bus.car_entered, bus.car_exited}, (lane < 2) ? 2'b10 : 2'b01);
    wait_idle({name, "_idle"});
  endtask

  initial begin
    int n;
    bit saw_exit;
    rst_n = 1'b0;
    bus.req = 4'd0;
    set_flags(4'd0);
    bus.car_passed = 1'b0;
    repeat (3) @(posedge clk);
    tick();
    started = 1'b1;
    check("reset_state", bus.state, 0);
    check("reset_gate", bus.gate_open, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_pulses", {bus.gnt, bus.deny, bus.car_entered, bus.car_exited, bus.timeout,
                           bus.is_uni_car_entered, bus.is_uni_car_exited}, 0);
    rst_n = 1'b1;

    // Uni entry, car present for three cycles.
    bus.uni_space_ok = 1'b1;
    bus.req = 4'b0001;
    tick();
    check("t1_gnt", bus.gnt, 4'b0001);
    check("t1_state_grant", bus.state, 1);
    bus.req = 4'd0;
    tick();
    check("t1_gate_open", bus.gate_open, 1);
    bus.car_passed = 1'b1;
    repeat (3) tick();
    check("t1_pass_state", bus.state, 3);
    bus.car_passed = 1'b0;
    tick();
    check("t1_entered", {bus.car_entered, bus.car_exited}, 2'b10);
    check("t1_uni_qual", bus.is_uni_car_entered, 1);
    check("t1_gate_closed_a", bus.gate_open, 0);
    tick();
    check("t1_single_pulse", bus.car_entered, 0);
    check("t1_cooldown", {bus.gate_open, bus.state}, {1'b0, 3'd4});
    tick();
    check("t1_idle", bus.state, 0);

    // Round-robin with all lanes requesting.
    do_reset();
    set_flags(4'b1111);
    bus.req = 4'b1111;
    wait_gnt("rr_0", 4'b0001); pass_car("rr_0", 0);
    wait_gnt("rr_1", 4'b0010); pass_car("rr_1", 1);
    wait_gnt("rr_2", 4'b0100); pass_car("rr_2", 2);
    wait_gnt("rr_3", 4'b1000); pass_car("rr_3", 3);
    wait_gnt("rr_4", 4'b0001);
    bus.req = 4'd0;
    pass_car("rr_4", 0);

    // Guest lot full: deny, then the next lane gets served.
    do_reset();
    set_flags(4'b1101);
    bus.req = 4'b0010;
    tick();
    check("deny_pulse", bus.deny, 4'b0010);
    check("deny_no_gnt", bus.gnt, 4'b0000);
    bus.req = 4'b0100;
    tick();
    check("deny_then_gnt", bus.gnt, 4'b0100);
    check("deny_pulse_gone", bus.deny, 4'b0000);
    bus.req = 4'd0;

    // Same uni-exit grant: no car ever arrives.
    tick();
    check("tmo_gate_rise", bus.gate_open, 1);
    n = 0;
    saw_exit = 1'b0;
    while (!bus.timeout && n < 40) begin
      tick();
      n++;
      if (bus.car_exited) saw_exit = 1'b1;
    end
    check("tmo_latency", n, To);
    check("tmo_no_commit", saw_exit, 0);
    check("tmo_gate_closed", bus.gate_open, 0);
    wait_idle("tmo_idle");

    // Car arrives on the very cycle the timer would expire.
    bus.req = 4'b1000;
    wait_gnt("edge_gnt", 4'b1000);
    bus.req = 4'd0;
    tick();
    repeat (To - 1) tick();
    bus.car_passed = 1'b1;
    tick();
    check("edge_pass_taken", {bus.timeout, bus.state}, {1'b0, 3'd3});
    bus.car_passed = 1'b0;
    tick();
    check("edge_commit", {bus.car_entered, bus.car_exited, bus.is_uni_car_exited}, 3'b010);
    wait_idle("edge_idle");

    // Reset in the middle of a pass.
    set_flags(4'b1111);
    bus.req = 4'b0010;
    wait_gnt("rst_gnt", 4'b0010);
    bus.req = 4'd0;
    tick();
    bus.car_passed = 1'b1;
    tick();
    check("rst_in_pass", bus.state, 3);
    rst_n = 1'b0;
    bus.car_passed = 1'b0;
    #1;
    check("rst_async", {bus.gate_open, bus.busy, bus.state}, 0);
    tick();
    check("rst_no_commit", {bus.car_entered, bus.car_exited}, 0);
    tick();
    rst_n = 1'b1;
    bus.req = 4'b1111;
    wait_gnt("rst_ptr_zero", 4'b0001);
    bus.req = 4'd0;
    pass_car("rst_after", 0);

    // Randomized traffic, model-checked every cycle.
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus.req = bus.req & ~(bus.gnt | bus.deny);
      if ($urandom_range(0, 3) == 0) bus.req = bus.req | 4'($urandom);
      if ($urandom_range(0, 15) == 0) set_flags(4'($urandom));
      if (bus.car_passed) begin
        if ($urandom_range(0, 2) == 0) bus.car_passed = 1'b0;
      end else if (bus.gate_open && $urandom_range(0, 19) == 0) begin
        bus.car_passed = 1'b1;
      end
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 699) == 0) rst_n = 1'b0;
    end

    rst_n = 1'b1;
    bus.req = 4'd0;
    bus.car_passed = 1'b0;
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
